// File: rtl/as_pack.sv
// rtl/as_pack.sv - shared constants and types for the as_top_mem GPIO write path
package as_pack;

  localparam int nr_gpios        = 16;
  localparam int gpio_addr_width = 8;
  localparam int gpio_fifo_depth = 4;
  localparam int gpio_strobe_cyc = 1;

  typedef struct packed {
    logic [gpio_addr_width-1:0] addr;
    logic [nr_gpios-1:0]        data;
  } gpio_wr_t;

  typedef enum logic [1:0] {IDLE, SETUP, STROBE, HOLD} gpio_seq_state_t;

endpackage

// File: rtl/as_gpio_wr_ctrl_if.sv
// rtl/as_gpio_wr_ctrl_if.sv - requester handshakes and GPIO pins of the write controller
interface as_gpio_wr_ctrl_if
  import as_pack::*;
#(
  parameter int NR_GPIOS = nr_gpios,
  parameter int ADDR_W   = gpio_addr_width
) ();

  logic                core_req_i;
  logic [ADDR_W-1:0]   core_addr_i;
  logic [NR_GPIOS-1:0] core_data_i;
  logic                core_gnt_o;
  logic                dbg_req_i;
  logic [ADDR_W-1:0]   dbg_addr_i;
  logic [NR_GPIOS-1:0] dbg_data_i;
  logic                dbg_gnt_o;
  logic [NR_GPIOS-1:0] gpio_o;
  logic [ADDR_W-1:0]   gpioAddr_o;
  logic                cs_o;
  logic                busy_o;

  modport slave (
    input  core_req_i, core_addr_i, core_data_i, dbg_req_i, dbg_addr_i, dbg_data_i,
    output core_gnt_o, dbg_gnt_o, gpio_o, gpioAddr_o, cs_o, busy_o
  );

  modport master (
    output core_req_i, core_addr_i, core_data_i, dbg_req_i, dbg_addr_i, dbg_data_i,
    input  core_gnt_o, dbg_gnt_o, gpio_o, gpioAddr_o, cs_o, busy_o
  );

endinterface

// File: rtl/as_gpio_wr_ctrl_fifo.sv
// rtl/as_gpio_wr_ctrl_fifo.sv - as_gpio_fifo: small synchronous write buffer
module as_gpio_fifo
  import as_pack::*;
#(
  parameter type entry_t = gpio_wr_t,
  parameter int  DEPTH   = gpio_fifo_depth,
  parameter int  AW      = $clog2(DEPTH),
  parameter int  CW      = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          push_i,
  input  entry_t        wdata_i,
  input  logic          pop_i,
  output entry_t        rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  entry_t        mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          do_push, do_pop;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      count_d = count_q + 1'b1;
    else if (!do_push && do_pop) count_d = count_q - 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: an entry is only read after being written.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/as_gpio_wr_ctrl.sv
// rtl/as_gpio_wr_ctrl.sv - round-robin write arbiter, buffer and setup/strobe/hold
// sequencer driving the memory-mapped GPIO output port.
module as_gpio_wr_ctrl
  import as_pack::*;
#(
  parameter int NR_GPIOS   = nr_gpios,
  parameter int ADDR_W     = gpio_addr_width,
  parameter int FIFO_DEPTH = gpio_fifo_depth,
  parameter int STROBE_CYC = gpio_strobe_cyc
) (
  input  logic               clk_i,
  input  logic               rst_i,
  as_gpio_wr_ctrl_if.slave   bus
);

  localparam int CW    = $clog2(FIFO_DEPTH + 1);
  localparam int CNT_W = (STROBE_CYC > 1) ? $clog2(STROBE_CYC) : 1;

  typedef struct packed {
    logic [ADDR_W-1:0]   addr;
    logic [NR_GPIOS-1:0] data;
  } wr_t;

  gpio_seq_state_t     state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NR_GPIOS-1:0] gpio_q, gpio_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                cs_q, cs_d;
  logic                rr_q, rr_d;
  logic                core_gnt, dbg_gnt, both;
  logic                fifo_full, fifo_empty, pop;
  logic [CW-1:0]       fifo_count;
  wr_t                 push_data, head;

  // rr_q = 0 favours the core, 1 favours debug; only consulted on contention.
  assign both     = bus.core_req_i && bus.dbg_req_i;
  assign core_gnt = !fifo_full && bus.core_req_i && (!bus.dbg_req_i || !rr_q);
  assign dbg_gnt  = !fifo_full && bus.dbg_req_i && (!bus.core_req_i || rr_q);
  assign rr_d     = (both && !fifo_full) ? !rr_q : rr_q;

  always_comb begin
    push_data = '0;
    if (core_gnt)     push_data = '{addr: bus.core_addr_i, data: bus.core_data_i};
    else if (dbg_gnt) push_data = '{addr: bus.dbg_addr_i, data: bus.dbg_data_i};
  end

  as_gpio_fifo #(
    .entry_t (wr_t),
    .DEPTH   (FIFO_DEPTH)
  ) u_fifo (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .push_i  (core_gnt || dbg_gnt),
    .wdata_i (push_data),
    .pop_i   (pop),
    .rdata_o (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .count_o (fifo_count)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gpio_d  = gpio_q;
    addr_d  = addr_q;
    pop     = 1'b0;
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          gpio_d  = head.data;
          addr_d  = head.addr;
          state_d = SETUP;
        end
      end
      SETUP: begin
        cnt_d   = '0;
        state_d = STROBE;
      end
      STROBE: begin
        if (cnt_q == CNT_W'(STROBE_CYC - 1)) state_d = HOLD;
        else                                 cnt_d   = cnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  // cs is registered from the next state so it is high exactly while in STROBE.
  assign cs_d = (state_d == STROBE);

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      gpio_q  <= '0;
      addr_q  <= '0;
      cs_q    <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gpio_q  <= gpio_d;
      addr_q  <= addr_d;
      cs_q    <= cs_d;
      rr_q    <= rr_d;
    end
  end

  assign bus.core_gnt_o = core_gnt;
  assign bus.dbg_gnt_o  = dbg_gnt;
  assign bus.gpio_o     = gpio_q;
  assign bus.gpioAddr_o = addr_q;
  assign bus.cs_o       = cs_q;
  assign bus.busy_o     = (fifo_count != '0) || (state_q != IDLE);

endmodule

// File: tb/tb_as_gpio_wr_ctrl.sv
// tb/tb_as_gpio_wr_ctrl.sv - bench for as_gpio_wr_ctrl at STROBE_CYC 1, 3 and 4
module tb_as_gpio_wr_ctrl;
  import as_pack::*;

  localparam int DW    = nr_gpios;
  localparam int AW    = gpio_addr_width;
  localparam int EW    = AW + DW;
  localparam int DEPTH = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n     [3];
  logic          core_req  [3];
  logic [AW-1:0] core_addr [3];
  logic [DW-1:0] core_data [3];
  logic          dbg_req   [3];
  logic [AW-1:0] dbg_addr  [3];
  logic [DW-1:0] dbg_data  [3];
  logic          core_gnt  [3];
  logic          dbg_gnt   [3];
  logic [DW-1:0] gpio      [3];
  logic [AW-1:0] gaddr     [3];
  logic          cs        [3];
  logic          busy      [3];
  int            sc_of     [3] = '{1, 3, 4};

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int SC = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    as_gpio_wr_ctrl_if #(.NR_GPIOS(DW), .ADDR_W(AW)) bus ();
    as_gpio_wr_ctrl #(
      .NR_GPIOS(DW), .ADDR_W(AW), .FIFO_DEPTH(DEPTH), .STROBE_CYC(SC)
    ) dut (
      .clk_i (clk),
      .rst_i (rst_n[g]),
      .bus   (bus)
    );
    assign bus.core_req_i  = core_req[g];
    assign bus.core_addr_i = core_addr[g];
    assign bus.core_data_i = core_data[g];
    assign bus.dbg_req_i   = dbg_req[g];
    assign bus.dbg_addr_i  = dbg_addr[g];
    assign bus.dbg_data_i  = dbg_data[g];
    assign core_gnt[g]     = bus.core_gnt_o;
    assign dbg_gnt[g]      = bus.dbg_gnt_o;
    assign gpio[g]         = bus.gpio_o;
    assign gaddr[g]        = bus.gpioAddr_o;
    assign cs[g]           = bus.cs_o;
    assign busy[g]         = bus.busy_o;
  end

  int vec = 0;
  int err = 0;
  int act = 0;
  int sc  = 1;

  // Pending writes of each requester; the head is what it presents.
  logic [EW-1:0] cq [$];
  logic [EW-1:0] dq [$];

  // Reference model: buffered writes, last write put on the pins, when it was
  // popped and the first cycle the sequencer can take another one.
  logic [EW-1:0] m_q [$];
  logic [EW-1:0] m_pins;
  int            m_cyc, m_pop_t, m_free;
  logic          m_rr;
  logic          e_gc, e_gd, e_cs, e_busy;

  logic          o_gc, o_gd, o_cs, o_busy;
  logic [AW-1:0] o_addr;
  logic [DW-1:0] o_gpio;

  task automatic m_reset();
    m_q.delete();
    m_pins  = '0;
    m_cyc   = 0;
    m_pop_t = -100;
    m_free  = 0;
    m_rr    = 1'b0;
  endtask

  task automatic m_eval();
    logic cr, dr, full;
    cr     = core_req[act];
    dr     = dbg_req[act];
    full   = (m_q.size() == DEPTH);
    e_gc   = !full && cr && (!dr || !m_rr);
    e_gd   = !full && dr && (!cr || m_rr);
    e_cs   = (m_cyc >= m_pop_t + 2) && (m_cyc <= m_pop_t + 1 + sc);
    e_busy = (m_q.size() != 0) || (m_cyc < m_free);
  endtask

  task automatic m_commit();
    if (m_q.size() > 0 && m_cyc >= m_free) begin
      m_pins = m_q[0];
      m_q.delete(0);
      m_pop_t = m_cyc;
      m_free  = m_cyc + sc + 3;
    end
    if (e_gc) m_q.push_back({core_addr[act], core_data[act]});
    if (e_gd) m_q.push_back({dbg_addr[act], dbg_data[act]});
    if (core_req[act] && dbg_req[act] && (e_gc || e_gd)) m_rr = !m_rr;
    m_cyc++;
  endtask

  task automatic drive();
    for (int k = 0; k < 3; k++) begin
      core_req[k] = 1'b0; core_addr[k] = '0; core_data[k] = '0;
      dbg_req[k]  = 1'b0; dbg_addr[k]  = '0; dbg_data[k]  = '0;
    end
    if (cq.size() > 0) begin
      core_req[act] = 1'b1;
      {core_addr[act], core_data[act]} = cq[0];
    end
    if (dq.size() > 0) begin
      dbg_req[act] = 1'b1;
      {dbg_addr[act], dbg_data[act]} = dq[0];
    end
  endtask

  task automatic sample();
    drive();
    @(negedge clk);
    m_eval();
    o_gc = core_gnt[act]; o_gd = dbg_gnt[act]; o_cs = cs[act];
    o_busy = busy[act]; o_addr = gaddr[act]; o_gpio = gpio[act];
  endtask

  task automatic advance();
    @(posedge clk);
    if (o_gc && cq.size() > 0) cq.delete(0);
    if (o_gd && dq.size() > 0) dq.delete(0);
    m_commit();
    #1;
  endtask

  task automatic do_reset(input int k);
    act = k;
    sc  = sc_of[k];
    cq.delete();
    dq.delete();
    drive();
    rst_n[k] = 1'b0;
    @(posedge clk);
    #1;
    rst_n[k] = 1'b1;
    m_reset();
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      vec++;
      if ({cs[k], busy[k], core_gnt[k], dbg_gnt[k], gpio[k], gaddr[k]} !== '0) begin
        err++;
        $display("FAIL reset inst %0d: cs %b busy %b gnt %b%b gpio %h addr %h, expected all 0",
                 k, cs[k], busy[k], core_gnt[k], dbg_gnt[k], gpio[k], gaddr[k]);
      end
    end
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_single();
    int gn = -1;
    do_reset(0);
    cq.push_back({8'd4, 16'd1});
    for (int c = 0; c < 10; c++) begin
      sample();
      vec++;
      if ({o_gc, o_gd, o_cs, o_busy} !== {e_gc, e_gd, e_cs, e_busy} || {o_addr, o_gpio} !== m_pins) begin
        err++;
        $display("FAIL single cyc %0d: gnt %b%b cs %b busy %b pins %h, expected gnt %b%b cs %b busy %b pins %h",
                 c, o_gc, o_gd, o_cs, o_busy, {o_addr, o_gpio}, e_gc, e_gd, e_cs, e_busy, m_pins);
      end
      if (o_gc && gn < 0) gn = c;
      if (gn >= 0 && c == gn + 2) begin
        vec++;
        if (o_gpio !== 16'd1 || o_addr !== 8'd4 || o_cs !== 1'b0) begin
          err++;
          $display("FAIL single_n2: gpio %h addr %h cs %b, expected 0001 04 0", o_gpio, o_addr, o_cs);
        end
      end
      if (gn >= 0 && c == gn + 3) begin
        vec++;
        if (o_cs !== 1'b1) begin err++; $display("FAIL single_n3: cs %b, expected 1", o_cs); end
      end
      if (gn >= 0 && c == gn + 4) begin
        vec++;
        if (o_cs !== 1'b0) begin err++; $display("FAIL single_n4: cs %b, expected 0", o_cs); end
      end
      if (gn >= 0 && c == gn + 5) begin
        vec++;
        if (o_busy !== 1'b0) begin err++; $display("FAIL single_n5: busy %b, expected 0", o_busy); end
      end
      advance();
    end
    vec++;
    if (gn !== 0) begin err++; $display("FAIL single_grant: grant cycle %0d, expected 0", gn); end
  endtask

  task automatic test_stream();
    logic [DW-1:0] exp_d [8] = '{16'd1, 16'd2, 16'd3, 16'd4, 16'd5, 16'd6, 16'd7, 16'h0080};
    logic [DW-1:0] got [$];
    int            rise [$];
    logic          prev = 1'b0;
    do_reset(0);
    for (int i = 0; i < 8; i++) cq.push_back({8'd4, exp_d[i]});
    for (int c = 0; c < 60; c++) begin
      sample();
      vec++;
      if ({o_gc, o_gd, o_cs, o_busy} !== {e_gc, e_gd, e_cs, e_busy} || {o_addr, o_gpio} !== m_pins) begin
        err++;
        $display("FAIL stream cyc %0d: gnt %b%b cs %b busy %b pins %h, expected gnt %b%b cs %b busy %b pins %h",
                 c, o_gc, o_gd, o_cs, o_busy, {o_addr, o_gpio}, e_gc, e_gd, e_cs, e_busy, m_pins);
      end
      if (o_cs && !prev) begin got.push_back(o_gpio); rise.push_back(c); end
      prev = o_cs;
      advance();
    end
    vec++;
    if (got.size() != 8) begin
      err++;
      $display("FAIL stream_count: %0d strobes, expected 8", got.size());
    end else begin
      for (int i = 0; i < 8; i++) begin
        vec++;
        if (got[i] !== exp_d[i]) begin
          err++;
          $display("FAIL stream_data %0d: %h, expected %h", i, got[i], exp_d[i]);
        end
        if (i > 0 && rise[i] - rise[i-1] != 4) begin
          err++;
          $display("FAIL stream_period %0d: %0d cycles, expected 4", i, rise[i] - rise[i-1]);
        end
      end
    end
  endtask

  task automatic test_contention();
    int gs [$];
    do_reset(0);
    for (int i = 0; i < 4; i++) begin
      cq.push_back({8'd1, 16'(($urandom_range(0, 255) << 1) | 0)});
      dq.push_back({8'd2, 16'(($urandom_range(0, 255) << 1) | 1)});
    end
    for (int c = 0; c < 60; c++) begin
      sample();
      vec++;
      if ({o_gc, o_gd, o_cs, o_busy} !== {e_gc, e_gd, e_cs, e_busy} || {o_addr, o_gpio} !== m_pins) begin
        err++;
        $display("FAIL contention cyc %0d: gnt %b%b cs %b busy %b pins %h, expected gnt %b%b cs %b busy %b pins %h",
                 c, o_gc, o_gd, o_cs, o_busy, {o_addr, o_gpio}, e_gc, e_gd, e_cs, e_busy, m_pins);
      end
      if (o_gc && o_gd) begin err++; $display("FAIL contention_dual cyc %0d: both gnt high", c); end
      if (core_req[act] && dbg_req[act] && (o_gc || o_gd)) gs.push_back(o_gd ? 1 : 0);
      advance();
    end
    vec++;
    if (gs.size() < 4) begin
      err++;
      $display("FAIL contention_grants: %0d grants under contention, expected >= 4", gs.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        if (gs[i] != i % 2) begin
          err++;
          $display("FAIL contention_order %0d: grant to %0d, expected %0d", i, gs[i], i % 2);
        end
      end
    end
  endtask

  task automatic test_full();
    logic [EW-1:0] sent [$];
    logic [EW-1:0] got [$];
    logic          prev = 1'b0;
    int            blocked = 0;
    do_reset(1);
    for (int i = 0; i < 6; i++) begin
      cq.push_back({8'($urandom_range(0, 255)), 16'($urandom)});
      sent.push_back(cq[i]);
    end
    for (int c = 0; c < 60; c++) begin
      sample();
      vec++;
      if ({o_gc, o_gd, o_cs, o_busy} !== {e_gc, e_gd, e_cs, e_busy} || {o_addr, o_gpio} !== m_pins) begin
        err++;
        $display("FAIL full cyc %0d: gnt %b%b cs %b busy %b pins %h, expected gnt %b%b cs %b busy %b pins %h",
                 c, o_gc, o_gd, o_cs, o_busy, {o_addr, o_gpio}, e_gc, e_gd, e_cs, e_busy, m_pins);
      end
      if (m_q.size() == DEPTH && core_req[act]) begin
        blocked++;
        vec++;
        if (o_gc !== 1'b0) begin err++; $display("FAIL full_block cyc %0d: gnt %b, expected 0", c, o_gc); end
      end
      if (o_cs && !prev) got.push_back({o_addr, o_gpio});
      prev = o_cs;
      advance();
    end
    vec++;
    if (blocked == 0 || got.size() != 6) begin
      err++;
      $display("FAIL full_stream: blocked %0d writes %0d, expected blocked > 0 and 6", blocked, got.size());
    end else begin
      for (int i = 0; i < 6; i++) if (got[i] !== sent[i]) begin
        err++;
        $display("FAIL full_data %0d: %h, expected %h", i, got[i], sent[i]);
      end
    end
  endtask

  task automatic test_reset_mid();
    int c = 0;
    do_reset(1);
    for (int i = 0; i < 3; i++) cq.push_back({8'(i + 8), 16'($urandom)});
    o_cs = 1'b0;
    while (!o_cs && c < 20) begin
      sample();
      vec++;
      if ({o_gc, o_gd, o_cs, o_busy} !== {e_gc, e_gd, e_cs, e_busy} || {o_addr, o_gpio} !== m_pins) begin
        err++;
        $display("FAIL resetmid cyc %0d: gnt %b%b cs %b busy %b pins %h, expected gnt %b%b cs %b busy %b pins %h",
                 c, o_gc, o_gd, o_cs, o_busy, {o_addr, o_gpio}, e_gc, e_gd, e_cs, e_busy, m_pins);
      end
      if (!o_cs) advance();
      c++;
    end
    vec++;
    if (!o_cs || m_q.size() != 2) begin
      err++;
      $display("FAIL resetmid_setup: cs %b with %0d buffered, expected 1 with 2", o_cs, m_q.size());
    end
    @(posedge clk);
    #1;
    do_reset(1);
    @(negedge clk);
    vec++;
    if ({cs[1], busy[1], gpio[1], gaddr[1]} !== '0) begin
      err++;
      $display("FAIL resetmid_clear: cs %b busy %b gpio %h addr %h, expected all 0", cs[1], busy[1], gpio[1], gaddr[1]);
    end
    for (int k = 0; k < 20; k++) begin
      sample();
      vec++;
      if (o_cs !== 1'b0 || o_busy !== 1'b0) begin
        err++;
        $display("FAIL resetmid_quiet cyc %0d: cs %b busy %b, expected 0 0", k, o_cs, o_busy);
      end
      advance();
    end
  endtask

  task automatic test_stability();
    int gn = -1;
    int strobes = 0;
    do_reset(2);
    dq.push_back({8'd4, 16'd3});
    for (int c = 0; c < 14; c++) begin
      sample();
      vec++;
      if ({o_gc, o_gd, o_cs, o_busy} !== {e_gc, e_gd, e_cs, e_busy} || {o_addr, o_gpio} !== m_pins) begin
        err++;
        $display("FAIL stable cyc %0d: gnt %b%b cs %b busy %b pins %h, expected gnt %b%b cs %b busy %b pins %h",
                 c, o_gc, o_gd, o_cs, o_busy, {o_addr, o_gpio}, e_gc, e_gd, e_cs, e_busy, m_pins);
      end
      if (o_gd && gn < 0) gn = c;
      if (gn >= 0 && c >= gn + 2 && c <= gn + 7) begin
        vec++;
        if (o_gpio !== 16'd3 || o_addr !== 8'd4) begin
          err++;
          $display("FAIL stable_pins cyc %0d: gpio %h addr %h, expected 0003 04", c, o_gpio, o_addr);
        end
      end
      if (o_cs) strobes++;
      advance();
    end
    vec++;
    if (strobes != 4) begin err++; $display("FAIL stable_strobes: %0d cs cycles, expected 4", strobes); end
  endtask

  task automatic test_random(input int k);
    do_reset(k);
    for (int c = 0; c < 300; c++) begin
      if (c < 200 && cq.size() < 3 && $urandom_range(0, 2) == 0) cq.push_back(EW'({$urandom, $urandom}));
      if (c < 200 && dq.size() < 3 && $urandom_range(0, 3) == 0) dq.push_back(EW'({$urandom, $urandom}));
      sample();
      vec++;
      if ({o_gc, o_gd, o_cs, o_busy} !== {e_gc, e_gd, e_cs, e_busy} || {o_addr, o_gpio} !== m_pins) begin
        err++;
        $display("FAIL random%0d cyc %0d: gnt %b%b cs %b busy %b pins %h, expected gnt %b%b cs %b busy %b pins %h",
                 k, c, o_gc, o_gd, o_cs, o_busy, {o_addr, o_gpio}, e_gc, e_gd, e_cs, e_busy, m_pins);
      end
      advance();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int k = 0; k < 3; k++) rst_n[k] = 1'b0;
    m_reset();
    test_reset();
    test_single();
    test_stream();
    test_contention();
    test_full();
    test_reset_mid();
    test_stability();
    test_random(0);
    test_random(1);
    test_random(2);
    $display("== %0d vectors applied, %0d miscompares ==", vec, err);
    $finish;
  end

endmodule

// File: doc/as_gpio_wr_ctrl.md
Name: as_gpio_wr_ctrl

Overview:
Write controller for the memory-mapped GPIO output port (gpio_o, gpioAddr_o, cs_o) of as_top_mem. Arbitrates round-robin between two write requesters: the core store path and the JTAG debug path. Buffers accepted writes in a small FIFO. Sequences each buffered write onto the GPIO pins as a setup/strobe/hold cycle, so gpio_o and gpioAddr_o are stable for the whole time cs_o is high.

Parameters:
NR_GPIOS, nr_gpios (as_pack), width of the GPIO data word
ADDR_W, gpio_addr_width (as_pack), width of the GPIO address
FIFO_DEPTH, 4, write buffer entries; power of two, >=2
STROBE_CYC, 1, cycles cs_o stays high per write; >=1

Ports:
clk_i  in  1  system clock; all logic on the rising edge
rst_i  in  1  reset; synchronous, active-low
core_req_i  in  1  core write request
core_addr_i  in  ADDR_W  core GPIO address
core_data_i  in  NR_GPIOS  core GPIO data
core_gnt_o  out  1  core write accepted this cycle
dbg_req_i  in  1  debug write request
dbg_addr_i  in  ADDR_W  debug GPIO address
dbg_data_i  in  NR_GPIOS  debug GPIO data
dbg_gnt_o  out  1  debug write accepted this cycle
gpio_o  out  NR_GPIOS  GPIO data, registered
gpioAddr_o  out  ADDR_W  GPIO address, registered
cs_o  out  1  GPIO chip select / strobe, registered
busy_o  out  1  FIFO non-empty or sequencer not IDLE

Behaviour:
- Reset (rst_i=0 at a rising edge): gpio_o=0, gpioAddr_o=0, cs_o=0, FIFO empty, sequencer IDLE, strobe counter 0, rr pointer=core. Any in-flight or buffered write is discarded. If reset hits during STROBE, cs_o is 0 after that edge.
- Handshake: a requester holds req, addr and data stable until it sees gnt. A transfer happens in the cycle where req=1 and gnt=1.
- Grant logic is combinational from req, FIFO full and the rr pointer. No grant is given while the FIFO is full. This holds even if a pop occurs in the same cycle; no push-through on full.
- Arbitration:
  - Only one requester active: that requester is granted, if not full.
  - Both active: the requester selected by the rr pointer is granted.
  - The pointer flips to the other requester after every grant made while both were requesting.
  - At most one gnt per cycle.
- FIFO: the entry is {addr, data}, written on a granted transfer and visible to the sequencer on the next cycle. Pointers wrap modulo FIFO_DEPTH. The count runs 0..FIFO_DEPTH. Push and pop in the same cycle (not full) keep the count unchanged.
- Sequencer FSM:
  - IDLE: if the FIFO is non-empty, pop the head, load gpio_o and gpioAddr_o from it, and go to SETUP.
  - SETUP: cs_o=0, outputs stable for 1 cycle; then go to STROBE with counter=0.
  - STROBE: cs_o=1. The counter increments each cycle; at counter=STROBE_CYC-1 go to HOLD.
  - HOLD: cs_o=0, data still held; then go to IDLE.
  - gpio_o and gpioAddr_o change only in IDLE when a pop occurs. Otherwise they keep their last value.
- Latency: a grant in cycle N puts the data on the pins at N+2 and raises cs_o at N+3 for STROBE_CYC cycles. A single write occupies STROBE_CYC+3 cycles, so back-to-back writes recur every STROBE_CYC+3 cycles.
- Data passes through unmodified: no sign or zero extension, full NR_GPIOS width.
- busy_o is combinational: (count!=0) | (state!=IDLE).

Decomposition:
- as_pack: NR_GPIOS/ADDR_W defaults (already present), plus new constants gpio_fifo_depth and gpio_strobe_cyc.
- as_pack also holds typedef gpio_wr_t (packed struct addr, data) and typedef enum gpio_seq_state_t {IDLE, SETUP, STROBE, HOLD}.
- One sub-module, as_gpio_fifo: synchronous-reset FIFO of gpio_wr_t with push, pop, full, empty and count.
- Arbiter and FSM stay in the top.

Test Plan:
- Single write, STROBE_CYC=1: core write addr=4 data=1 granted at N -> gpio_o=1 and gpioAddr_o=4 at N+2; cs_o=1 only at N+3; cs_o=0 at N+4; busy_o=0 at N+5.
- Ordered stream: core writes addr 4, data 1..7 then 0x80 back-to-back -> cs_o pulses show data 1,2,...,7,0x80 in order, every 4 cycles; 0x80 appears unextended.
- Contention: both requesters held active with distinct data, with FIFO space -> grants alternate core, dbg, core, dbg. Never two gnt in one cycle.
- Full: FIFO_DEPTH=4, STROBE_CYC=3, six core writes back-to-back -> core_gnt_o held low in the cycle after the FIFO holds 4 entries. Grants resume only after the next pop. All six writes appear on cs_o, none lost or duplicated.
- Reset mid-strobe: assert rst_i=0 while cs_o=1 with 2 entries buffered -> after that edge cs_o=0, gpio_o=0, gpioAddr_o=0, busy_o=0. Release reset -> no further cs_o pulse until a new write.
- Address/data stability: STROBE_CYC=4 with a debug write addr=4 data=3 -> gpio_o and gpioAddr_o unchanged during SETUP, all 4 STROBE cycles and HOLD.
